// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared types for the data-memory arbiter.
// Requester IDs, phase encodings, read tags and the phase mask.
package dm_arb_pkg;

   localparam int NREQ = 3;

   typedef enum logic [1:0] {
      REQ_RX  = 2'd0,
      REQ_CPU = 2'd1,
      REQ_TX  = 2'd2
   } req_id_t;

   typedef enum logic [1:0] {
      PH_IDLE = 2'b00,
      PH_RECV = 2'b01,
      PH_PROC = 2'b10,
      PH_XMIT = 2'b11
   } phase_t;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_CPU  = 2'd1,
      TAG_TX   = 2'd2
   } tag_t;

   // bit order of the mask is {tx, cpu, rx}
   function automatic logic [NREQ-1:0] phase_mask(input logic [1:0] ph);
      logic [NREQ-1:0] m;
      case (phase_t'(ph))
         PH_RECV: m = 3'b011;
         PH_PROC: m = 3'b010;
         PH_XMIT: m = 3'b110;
         default: m = 3'b000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/dm_arbiter_rr.sv
// rr_arbiter3: combinational 3-way round-robin pick.
// Highest priority goes to the requester named by ptr.
module rr_arbiter3
   import dm_arb_pkg::*;
(
   input  logic [NREQ-1:0] elig,
   input  req_id_t         ptr,
   output logic [NREQ-1:0] pick
);

   // walk from lowest to highest priority so the highest one wins
   always_comb begin
      pick = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         automatic int idx = (int'(ptr) + k) % NREQ;
         if (elig[idx[1:0]]) begin
            pick = '0;
            pick[idx[1:0]] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data DRAM between
// the UART receiver, the processor and the transmitter.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int AW     = 20,
   parameter int DW     = 8,
   parameter int RD_LAT = 1
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic [1:0]    status,
   input  logic          rx_req,
   input  logic [AW-1:0] rx_addr,
   input  logic [DW-1:0] rx_wdata,
   output logic          rx_gnt,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          tx_req,
   input  logic [AW-1:0] tx_addr,
   output logic          tx_gnt,
   output logic          tx_rvalid,
   output logic [DW-1:0] tx_rdata,
   output logic [AW-1:0] dm_addr,
   output logic [DW-1:0] dm_data,
   output logic          dm_wren,
   output logic          dm_rden,
   input  logic [DW-1:0] dm_q
);

   req_id_t         ptr;
   logic [NREQ-1:0] elig;
   logic [NREQ-1:0] pick;
   tag_t            cur_tag;
   tag_t            rd_tag [RD_LAT+1];

   // a requester already holding gnt is skipped this cycle
   always_comb begin
      elig = {tx_req, cpu_req, rx_req}
           & phase_mask(status)
           & ~{tx_gnt, cpu_gnt, rx_gnt};
   end

   rr_arbiter3 u_rr (
      .elig (elig),
      .ptr  (ptr),
      .pick (pick)
   );

   // register grant pulses and the DRAM command of the winner
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_gnt  <= 1'b0;
         cpu_gnt <= 1'b0;
         tx_gnt  <= 1'b0;
         dm_wren <= 1'b0;
         dm_rden <= 1'b0;
         dm_addr <= '0;
         dm_data <= '0;
         ptr     <= REQ_RX;
      end else begin
         rx_gnt  <= pick[0];
         cpu_gnt <= pick[1];
         tx_gnt  <= pick[2];
         dm_wren <= pick[0] | (pick[1] & cpu_we);
         dm_rden <= pick[2] | (pick[1] & ~cpu_we);
         if (pick[0]) begin
            dm_addr <= rx_addr;
            dm_data <= rx_wdata;
            ptr     <= REQ_CPU;
         end else if (pick[1]) begin
            dm_addr <= cpu_addr;
            if (cpu_we) dm_data <= cpu_wdata;
            ptr     <= REQ_TX;
         end else if (pick[2]) begin
            dm_addr <= tx_addr;
            ptr     <= REQ_RX;
         end
      end
   end

   // tag of the read being issued on the DRAM pins this cycle
   always_comb begin
      cur_tag = TAG_NONE;
      if (tx_gnt) cur_tag = TAG_TX;
      else if (cpu_gnt && dm_rden) cur_tag = TAG_CPU;
   end

   // track each read until its data appears on dm_q
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i <= RD_LAT; i++) rd_tag[i] <= TAG_NONE;
      end else begin
         rd_tag[0] <= cur_tag;
         for (int i = 1; i <= RD_LAT; i++) rd_tag[i] <= rd_tag[i-1];
      end
   end

   // capture returning data into the port that issued the read
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cpu_rvalid <= 1'b0;
         tx_rvalid  <= 1'b0;
         cpu_rdata  <= '0;
         tx_rdata   <= '0;
      end else begin
         cpu_rvalid <= (rd_tag[RD_LAT] == TAG_CPU);
         tx_rvalid  <= (rd_tag[RD_LAT] == TAG_TX);
         if (rd_tag[RD_LAT] == TAG_CPU) cpu_rdata <= dm_q;
         if (rd_tag[RD_LAT] == TAG_TX)  tx_rdata  <= dm_q;
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter.
// Covers RD_LAT=1 (main instance) and RD_LAT=2 (tx only).
module tb_dm_arbiter;

   localparam int AW = 20;
   localparam int DW = 8;

   typedef struct {
      int         cyc;
      logic [7:0] data;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [1:0]    status;
   logic          rx_req;
   logic [AW-1:0] rx_addr;
   logic [DW-1:0] rx_wdata;
   logic          rx_gnt;
   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt, cpu_rvalid;
   logic [DW-1:0] cpu_rdata;
   logic          tx_req;
   logic [AW-1:0] tx_addr;
   logic          tx_gnt, tx_rvalid;
   logic [DW-1:0] tx_rdata;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_data;
   logic          dm_wren, dm_rden;
   logic [DW-1:0] dm_q;

   logic          b_tx_req;
   logic [AW-1:0] b_tx_addr;
   logic          b_rx_gnt, b_cpu_gnt, b_cpu_rvalid;
   logic          b_tx_gnt, b_tx_rvalid;
   logic [DW-1:0] b_cpu_rdata, b_tx_rdata;
   logic [AW-1:0] b_dm_addr;
   logic [DW-1:0] b_dm_data;
   logic          b_dm_wren, b_dm_rden;
   logic [DW-1:0] b_dm_q;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int g_cnt [3] = '{0, 0, 0};
   int busy_cnt = 0;
   int cpu_rv_cnt = 0;
   int gnt_log [$];
   exp_t cpu_q [$];
   exp_t tx_q [$];
   exp_t b_q [$];

   logic [7:0] mq1 [0:1];
   logic [7:0] mq2 [0:2];

   dm_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) u_dut (
      .clock(clock), .reset_n(reset_n), .status(status),
      .rx_req(rx_req), .rx_addr(rx_addr), .rx_wdata(rx_wdata),
      .rx_gnt(rx_gnt),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
      .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .tx_req(tx_req), .tx_addr(tx_addr), .tx_gnt(tx_gnt),
      .tx_rvalid(tx_rvalid), .tx_rdata(tx_rdata),
      .dm_addr(dm_addr), .dm_data(dm_data),
      .dm_wren(dm_wren), .dm_rden(dm_rden), .dm_q(dm_q)
   );

   dm_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2)) u_dut2 (
      .clock(clock), .reset_n(reset_n), .status(2'b11),
      .rx_req(1'b0), .rx_addr('0), .rx_wdata('0),
      .rx_gnt(b_rx_gnt),
      .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr('0),
      .cpu_wdata('0), .cpu_gnt(b_cpu_gnt),
      .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
      .tx_req(b_tx_req), .tx_addr(b_tx_addr), .tx_gnt(b_tx_gnt),
      .tx_rvalid(b_tx_rvalid), .tx_rdata(b_tx_rdata),
      .dm_addr(b_dm_addr), .dm_data(b_dm_data),
      .dm_wren(b_dm_wren), .dm_rden(b_dm_rden), .dm_q(b_dm_q)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // DRAM models: address sampled with rden, data RD_LAT edges later
   always @(posedge clock) begin
      if (dm_rden) mq1[0] <= dm_addr[7:0];
      mq1[1] <= mq1[0];
      if (b_dm_rden) mq2[0] <= b_dm_addr[7:0];
      mq2[1] <= mq2[0];
      mq2[2] <= mq2[1];
   end
   assign dm_q   = mq1[1];
   assign b_dm_q = mq2[2];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // grant log, expectation push and read-return scoreboard
   always @(negedge clock) begin
      exp_t e;
      if (reset_n) begin
         if (rx_gnt) begin
            g_cnt[0]++;
            gnt_log.push_back(0);
         end
         if (cpu_gnt) begin
            g_cnt[1]++;
            gnt_log.push_back(1);
            chk("cpu_dm_addr", dm_addr, cpu_addr);
            if (dm_rden) cpu_q.push_back('{cyc + 3, cpu_addr[7:0]});
         end
         if (tx_gnt) begin
            g_cnt[2]++;
            gnt_log.push_back(2);
            chk("tx_dm_addr", dm_addr, tx_addr);
            tx_q.push_back('{cyc + 3, tx_addr[7:0]});
         end
         if (b_tx_gnt) b_q.push_back('{cyc + 4, b_tx_addr[7:0]});
         if (dm_wren || dm_rden) busy_cnt++;
         if (cpu_rvalid) cpu_rv_cnt++;

         if (cpu_rvalid) begin
            if (cpu_q.size() == 0) chk("cpu_spurious", cpu_rvalid, 0);
            else begin
               e = cpu_q.pop_front();
               chk("cpu_rdata", cpu_rdata, e.data);
               chk("cpu_lat", cyc, e.cyc);
            end
         end else if (cpu_q.size() != 0 && cpu_q[0].cyc < cyc) begin
            e = cpu_q.pop_front();
            chk("cpu_missing", cpu_rvalid, 1);
         end

         if (tx_rvalid) begin
            if (tx_q.size() == 0) chk("tx_spurious", tx_rvalid, 0);
            else begin
               e = tx_q.pop_front();
               chk("tx_rdata", tx_rdata, e.data);
               chk("tx_lat", cyc, e.cyc);
            end
         end else if (tx_q.size() != 0 && tx_q[0].cyc < cyc) begin
            e = tx_q.pop_front();
            chk("tx_missing", tx_rvalid, 1);
         end

         if (b_tx_rvalid) begin
            if (b_q.size() == 0) chk("b_spurious", b_tx_rvalid, 0);
            else begin
               e = b_q.pop_front();
               chk("b_rdata", b_tx_rdata, e.data);
               chk("b_lat", cyc, e.cyc);
            end
         end else if (b_q.size() != 0 && b_q[0].cyc < cyc) begin
            e = b_q.pop_front();
            chk("b_missing", b_tx_rvalid, 1);
         end
      end
   end

   task automatic wait_gnt(input int id, input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clock);
         case (id)
            0:       seen = rx_gnt;
            1:       seen = cpu_gnt;
            3:       seen = b_tx_gnt;
            default: seen = tx_gnt;
         endcase
      end
      chk(tag, seen, 1);
   endtask

   initial begin
      int c0, nc, nt;
      reset_n = 1'b0;
      status = 2'b00;
      rx_req = 0; rx_addr = '0; rx_wdata = '0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      tx_req = 0; tx_addr = '0;
      b_tx_req = 0; b_tx_addr = '0;

      repeat (2) @(negedge clock);
      chk("rst_gnt", {rx_gnt, cpu_gnt, tx_gnt}, 0);
      chk("rst_cmd", {dm_wren, dm_rden}, 0);
      chk("rst_addr", dm_addr, 0);
      chk("rst_data", dm_data, 0);
      chk("rst_rdata", {cpu_rdata, tx_rdata}, 0);
      chk("rst_rvalid", {cpu_rvalid, tx_rvalid}, 0);
      #2 reset_n = 1'b1;

      // receive phase: one rx write
      status = 2'b01;
      rx_addr = 20'h00010; rx_wdata = 8'h5A; rx_req = 1;
      wait_gnt(0, "rx_gnt");
      chk("rx_wren", dm_wren, 1);
      chk("rx_rden", dm_rden, 0);
      chk("rx_addr", dm_addr, 20'h00010);
      chk("rx_data", dm_data, 8'h5A);
      #2 rx_req = 0;
      c0 = g_cnt[0];
      repeat (4) @(negedge clock);
      chk("rx_single", g_cnt[0] - c0, 0);

      // process phase: rx and tx are masked
      #2 status = 2'b10; rx_req = 1; tx_req = 1;
      c0 = busy_cnt;
      repeat (6) @(negedge clock);
      chk("proc_idle", busy_cnt - c0, 0);
      chk("proc_cmd", {dm_wren, dm_rden}, 0);
      #2 rx_req = 0; tx_req = 0;

      // transmit phase: cpu and tx stream reads
      status = 2'b11; cpu_we = 0;
      cpu_addr = 20'h00121; tx_addr = 20'h00A40;
      gnt_log.delete();
      nc = 0; nt = 0;
      cpu_req = 1; tx_req = 1;
      for (int i = 0; i < 40 && (cpu_req || tx_req); i++) begin
         @(negedge clock);
         #2;
         if (cpu_gnt) begin
            nc++;
            if (nc < 4) cpu_addr = cpu_addr + 20'd7;
            else cpu_req = 0;
         end
         if (tx_gnt) begin
            nt++;
            if (nt < 4) tx_addr = tx_addr + 20'd13;
            else tx_req = 0;
         end
      end
      repeat (6) @(negedge clock);
      chk("rr_count", gnt_log.size(), 8);
      for (int i = 1; i < gnt_log.size(); i++)
         chk("rr_alternate", gnt_log[i] != gnt_log[i-1], 1);
      chk("rr_cpu_drain", cpu_q.size(), 0);
      chk("rr_tx_drain", tx_q.size(), 0);

      // phase change after a cpu read grant
      #2 status = 2'b11; cpu_addr = 20'h0003C; cpu_req = 1;
      wait_gnt(1, "ph_cpu_gnt");
      #2 cpu_req = 0; status = 2'b01;
      tx_addr = 20'h00055; tx_req = 1;
      c0 = g_cnt[2];
      repeat (6) @(negedge clock);
      chk("ph_no_tx", g_cnt[2] - c0, 0);
      chk("ph_cpu_drain", cpu_q.size(), 0);
      #2 tx_req = 0;

      // reset right after a cpu read grant
      status = 2'b11; cpu_addr = 20'h00077; cpu_req = 1;
      wait_gnt(1, "rs_cpu_gnt");
      #2 reset_n = 1'b0;
      #1;
      chk("rs_gnt", cpu_gnt, 0);
      chk("rs_rden", dm_rden, 0);
      chk("rs_addr", dm_addr, 0);
      cpu_q.delete();
      cpu_req = 0;
      @(negedge clock);
      #2 reset_n = 1'b1;
      c0 = cpu_rv_cnt;
      repeat (6) @(negedge clock);
      chk("rs_no_rvalid", cpu_rv_cnt - c0, 0);
      #2 cpu_addr = 20'h00099; tx_addr = 20'h000AB;
      cpu_req = 1; tx_req = 1;
      c0 = 0;
      for (int i = 0; i < 20 && c0 == 0; i++) begin
         @(negedge clock);
         if (cpu_gnt || tx_gnt) c0 = 1;
      end
      chk("rs_first_cpu", cpu_gnt, 1);
      chk("rs_first_not_tx", tx_gnt, 0);
      #2 cpu_req = 0;
      wait_gnt(2, "rs_tx_next");
      #2 tx_req = 0;
      repeat (6) @(negedge clock);
      chk("rs_cpu_drain", cpu_q.size(), 0);
      chk("rs_tx_drain", tx_q.size(), 0);

      // RD_LAT=2 instance: tx read
      #2 b_tx_addr = 20'h000E5; b_tx_req = 1;
      wait_gnt(3, "b_tx_gnt");
      #2 b_tx_req = 0;
      repeat (7) @(negedge clock);
      chk("b_drain", b_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Shares the single-port data-memory DRAM (8-bit data, 20-bit address) between three requesters: the UART receiver (image load, writes only), the processor (reads and writes) and the transmitter (result readout, reads only). It sits between those blocks and the DRAM's address/data/wren/rden/q pins, replacing the ad-hoc address muxes. It grants at most one access per cycle, round-robin among requesters enabled by the current main-controller phase, and returns read data to whichever requester issued the read.

## Interface
- `AW`, 20, address width
- `DW`, 8, data width
- `RD_LAT`, 1, DRAM clock cycles from the rden sample edge to valid `dm_q` (1 or 2)

Ports:
- `clock` in 1 system clock
- `reset_n` in 1 asynchronous, active-low reset
- `status` in 2 phase from main controller: 00 idle, 01 receive, 10 process, 11 transmit
- `rx_req`, `rx_addr[AW]`, `rx_wdata[DW]` in; `rx_gnt` out 1: receiver write port
- `cpu_req`, `cpu_we`, `cpu_addr[AW]`, `cpu_wdata[DW]` in; `cpu_gnt`, `cpu_rvalid` out 1; `cpu_rdata` out DW: processor port
- `tx_req`, `tx_addr[AW]` in; `tx_gnt`, `tx_rvalid` out 1; `tx_rdata` out DW: transmitter read port
- `dm_addr` out AW, `dm_data` out DW, `dm_wren` out 1, `dm_rden` out 1: DRAM command
- `dm_q` in DW: DRAM read data

## Operation
- Phase eligibility mask:
  - 00: none
  - 01: rx, cpu
  - 10: cpu only
  - 11: cpu, tx
- Eligible = req & mask & ~gnt (a requester whose gnt is high this cycle is not considered, so a held req is not double-granted).
- Round-robin order rx→cpu→tx. Priority starts at the requester after the last granted one. Pointer resets to rx; it advances only on a grant.
- Grant: one-cycle `*_gnt` pulse. In the same cycle, `dm_addr`/`dm_data`/`dm_wren`/`dm_rden` carry the granted command.
  - rx: always write.
  - cpu: write if `cpu_we`, else read.
  - tx: always read.
  - Exactly one of wren/rden is high on a grant cycle; both are low otherwise.
- Requester handshake: hold req/addr/wdata/we stable until gnt is seen high; drop req or present the next request in the following cycle.
- Read return: a tag pipeline of depth RD_LAT+1 records the reader (cpu/tx). When the tag emerges, the arbiter registers `dm_q` into that port's rdata and pulses its rvalid for one cycle. rdata holds until the next rvalid for that port.
- Status change: affects new grants only. In-flight reads still complete and deliver rvalid, even if the new phase masks that requester.
- Writes have no completion response.

## Timing
- Request high before edge E0 → gnt and dm command valid in cycle E0..E1; DRAM samples at E1.
- Read: rvalid/rdata valid in the cycle starting at edge E1+RD_LAT+1, i.e. RD_LAT+2 cycles after gnt (RD_LAT=1: gnt at cycle n, rvalid at n+3).
- Throughput: one access per cycle total. A single requester holding req continuously gets every other cycle.
- Idle: `dm_wren`=`dm_rden`=0; `dm_addr`/`dm_data` hold their last values.
- Reset values:
  - all gnt, rvalid, `dm_wren`, `dm_rden` = 0
  - `dm_addr`, `dm_data`, `cpu_rdata`, `tx_rdata` = 0
  - pointer = rx
  - tag pipeline cleared
- Reset mid-operation discards in-flight reads: no rvalid appears after reset deasserts.

## Structure
- Package `dm_arb_pkg`:
  - requester IDs REQ_RX=0, REQ_CPU=1, REQ_TX=2
  - phase encodings PH_IDLE/PH_RECV/PH_PROC/PH_XMIT
  - phase→mask function
  - tag type (2-bit: none/cpu/tx)
- Sub-module `rr_arbiter3`: combinational 3-way round-robin pick from eligible vector and pointer, returning one-hot grant. All registers stay in dm_arbiter.

## Test plan
- status=01, rx_req with addr 0x00010, data 0x5A held 3 cycles → single rx_gnt pulse; dm_wren=1 with addr 0x00010, data 0x5A in that cycle; no second grant.
- status=11, cpu and tx request reads continuously (DRAM model returns addr[7:0]) → grants alternate cpu, tx, cpu, tx. Each rvalid arrives 3 cycles after its gnt (RD_LAT=1) with correct data on the correct port only.
- status=10, rx_req and tx_req high, cpu idle → no grants, dm_wren/dm_rden stay 0.
- cpu read granted, status switches 11→01 the next cycle → cpu_rvalid still arrives at gnt+3; tx is no longer granted.
- RD_LAT=2 build, tx read → tx_rvalid at gnt+4.
- reset_n pulsed low for one cycle right after a cpu read gnt → outputs zero asynchronously; no cpu_rvalid afterwards; first grant after reset follows the rx-first order.
